line_draw: RTL
==============

LINE_DRAW -- requirements
Module: line_draw

Interface
REQ-001 Parameter: COORD_W, default 9, coordinate width in bits, matching the SoC x1/x2/y1/y2 outputs.
REQ-002 HCLK  input  1  system clock; all state updates on the rising edge.
REQ-003 HRESETn  input  1  reset; asynchronous and active-low.
REQ-004 x1, y1  input  COORD_W each  line start point, unsigned.
REQ-005 x2, y2  input  COORD_W each  line end point, unsigned.
REQ-006 start  input  1  request to draw; sampled only in IDLE.
REQ-007 pix_ready  input  1  downstream framebuffer accepts the current pixel.
REQ-008 pix_x, pix_y  output  COORD_W each  current pixel coordinate.
REQ-009 pix_valid  output  1  pix_x/pix_y hold a valid pixel.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SETUP, DRAW, FINISH.
REQ-013 IDLE with start=1 SHALL latch x1, y1, x2, y2 and move to SETUP; start=0 SHALL stay in IDLE.
REQ-014 SETUP (one cycle) SHALL compute the following, then move to DRAW:
  - dx = |x2-x1|, dy = -|y2-y1|
  - sx = +1 if x2>=x1 else -1; sy = +1 if y2>=y1 else -1
  - err = dx+dy
  - current point = (x1, y1)
REQ-015 err SHALL be signed, COORD_W+2 bits; e2 = 2*err SHALL be signed, COORD_W+3 bits; no overflow for any legal input.
REQ-016 In DRAW, pix_valid SHALL be 1 and pix_x/pix_y SHALL equal the current point; first pix_valid occurs 2 cycles after start is sampled.
REQ-017 While pix_valid=1 and pix_ready=0, pix_x, pix_y, pix_valid and internal state SHALL hold unchanged.
REQ-018 A transfer occurs on a cycle with pix_valid=1 and pix_ready=1.
REQ-019 On a transfer where the current point equals (x2, y2), the FSM SHALL move to FINISH.
REQ-020 On any other transfer, the block SHALL apply one Bresenham step in the same cycle:
  - if e2>=dy: err+=dy and x+=sx
  - if e2<=dx: err+=dx and y+=sy
  - both adjustments use the pre-step err and sum when both conditions hold
REQ-021 With pix_ready held at 1, the block SHALL emit one pixel per cycle, max(dx,|dy|)+1 pixels in total, each point exactly once.
REQ-022 FINISH SHALL last one cycle, with done=1 and pix_valid=0, then return to IDLE.
REQ-023 start SHALL be ignored in SETUP, DRAW and FINISH; a start in the FINISH cycle is lost, and the earliest accepted start is the cycle after done.
REQ-024 x1, y1, x2, y2 changes SHALL have no effect after latching.
REQ-025 A degenerate line (x1=x2 and y1=y2) SHALL produce exactly one pixel and then done.
REQ-026 Coordinates SHALL never leave the bounding box of the two endpoints; no wrap-around occurs.

Reset
REQ-027 Asserting HRESETn=0 at any time, including mid-line, SHALL immediately force IDLE and set pix_x=0, pix_y=0, pix_valid=0, busy=0, done=0 and all internal registers to 0.
REQ-028 After HRESETn deasserts, the block SHALL remain idle until start is sampled high.

Verification
REQ-029 Horizontal line: (0,0)->(3,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; done one cycle after (3,0).
REQ-030 Steep line: (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3). Reverse diagonal: (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2).
REQ-031 Backpressure: (0,0)->(2,1) with pix_ready=0 for 3 cycles on the second pixel -> (1,1) held stable; sequence (0,0),(1,1),(2,1) intact.
REQ-032 Single point: (7,9)->(7,9) -> exactly one pixel (7,9), then a done pulse.
REQ-033 Max span: (511,0)->(0,511) -> 512 pixels, first (511,0), last (0,511), no wrap.
REQ-034 Control events:
  - HRESETn low during pixel 2 of (0,0)->(10,0) -> all outputs 0 asynchronously.
  - Post-reset start of (1,1)->(2,2) draws correctly.
  - start pulsed during DRAW -> ignored.

Source files
------------

// File: rtl/line_draw.sv
// Bresenham line rasterizer: latches two endpoints, then streams one pixel per
// accepted handshake and pulses done after the final endpoint is taken.
module line_draw #(
   parameter int COORD_W = 9
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic               start,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_valid,
   output logic               busy,
   output logic               done
);

   localparam int EW = COORD_W + 2;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;

   state_t               state;
   logic [COORD_W-1:0]   lx1, ly1, lx2, ly2;
   logic signed [EW-1:0] dx, dy, err;
   logic                 sx_neg, sy_neg;

   logic [EW-1:0]        abs_x, abs_y;
   logic signed [EW:0]   e2, dx_e, dy_e;
   logic signed [EW-1:0] err_nxt;
   logic                 step_x, step_y, at_end;

   assign abs_x = (lx2 >= lx1) ? EW'(lx2) - EW'(lx1) : EW'(lx1) - EW'(lx2);
   assign abs_y = (ly2 >= ly1) ? EW'(ly2) - EW'(ly1) : EW'(ly1) - EW'(ly2);

   // e2 = 2*err, compared against sign-extended dx/dy one bit wider
   assign e2      = {err, 1'b0};
   assign dx_e    = {dx[EW-1], dx};
   assign dy_e    = {dy[EW-1], dy};
   assign step_x  = (e2 >= dy_e);
   assign step_y  = (e2 <= dx_e);
   assign err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
   assign at_end  = (pix_x == lx2) && (pix_y == ly2);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         lx1       <= '0;
         ly1       <= '0;
         lx2       <= '0;
         ly2       <= '0;
         dx        <= '0;
         dy        <= '0;
         err       <= '0;
         sx_neg    <= 1'b0;
         sy_neg    <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lx1   <= x1;
                  ly1   <= y1;
                  lx2   <= x2;
                  ly2   <= y2;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               dx        <= abs_x;
               dy        <= -abs_y;
               err       <= abs_x - abs_y;
               sx_neg    <= (lx2 < lx1);
               sy_neg    <= (ly2 < ly1);
               pix_x     <= lx1;
               pix_y     <= ly1;
               pix_valid <= 1'b1;
               state     <= DRAW;
            end
            DRAW: begin
               // everything holds while the framebuffer stalls
               if (pix_ready) begin
                  if (at_end) begin
                     pix_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= FINISH;
                  end else begin
                     err <= err_nxt;
                     if (step_x) pix_x <= sx_neg ? pix_x - 1'b1 : pix_x + 1'b1;
                     if (step_y) pix_y <= sy_neg ? pix_y - 1'b1 : pix_y + 1'b1;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
